lampfpu_log_norm: RTL and testbench

Normalization and rounding stage directly downstream of the lampFPU logarithm datapath. It takes the unsigned fixed-point magnitude of ln(x) and the result sign produced by the log stage, together with the operand special-case flags. It produces a bfloat16 result (1/8/7) rounded to nearest-even. Normalization is iterative, one bit per cycle, under a ready/valid input handshake. Its outputs feed the lampFPU result mux alongside the other FPU ops.

---
 rtl/lampfpu_log_norm.sv | 162 ++++++++++++++++
 tb/tb_lampfpu_log_norm.sv | 135 +++++++++++++
 2 files changed

// File: rtl/lampfpu_log_norm.sv
// lampfpu_log_norm: normalizes |ln(x)| and rounds it to bfloat16 with
// round-to-nearest-even. Normalization shifts one bit per cycle. Operand
// special cases skip normalization and return a fixed encoding.
module lampfpu_log_norm #(
  parameter int Z_DW   = 25,
  parameter int Z_FRAC = 16,
  parameter int E_DW   = 8,
  parameter int F_DW   = 7,
  parameter int BIAS   = 127
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            s_i,
  input  logic [Z_DW-1:0] z_i,
  input  logic            isZ_i,
  input  logic            isInf_i,
  input  logic            isNaN_i,
  input  logic            isNeg_i,
  output logic            s_res_o,
  output logic [E_DW-1:0] e_res_o,
  output logic [F_DW-1:0] f_res_o,
  output logic            valid_o,
  output logic            isOverflow_o,
  output logic            isUnderflow_o,
  output logic            isToRound_o
);

  // The exponent of the MSB of z_i is (Z_DW-1-Z_FRAC). Every normalizing
  // shift lowers that by one.
  localparam logic [E_DW-1:0] EXP_INIT = E_DW'(BIAS + Z_DW - 1 - Z_FRAC);
  // Bits below the guard bit. All of them feed sticky.
  localparam int              ST_DW    = Z_DW - 2 - F_DW;
  localparam logic [E_DW-1:0] EXP_ONES = '1;
  localparam logic [F_DW-1:0] QNAN_F   = F_DW'(1) << (F_DW - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t          state, stateNext;
  logic [Z_DW-1:0] mant;
  // The exponent stays within 111..136, so E_DW bits are enough and it never wraps.
  logic [E_DW-1:0] exp;
  logic            sign;
  logic            special;
  logic            flagZ, flagInf, flagNaN, flagNeg;

  logic            anySpecialIn;
  logic [F_DW-1:0] frac;
  logic            guard, sticky, incr;
  logic [F_DW:0]   fracSum;
  logic            rSign;
  logic [E_DW-1:0] rExp;
  logic [F_DW-1:0] rFrac;
  logic            rInexact;

  assign anySpecialIn  = isZ_i | isInf_i | isNaN_i | isNeg_i | (z_i == '0);
  assign ready_o       = (state == IDLE);
  assign valid_o       = (state == DONE);
  assign isOverflow_o  = 1'b0;
  assign isUnderflow_o = 1'b0;

  // State register, operand capture, shift-normalize, and the result registers.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking. Each register then
    // samples values from before the edge, whatever the statement order is.
    if (rst) begin
      state       <= IDLE;
      mant        <= '0;
      exp         <= '0;
      sign        <= 1'b0;
      special     <= 1'b0;
      flagZ       <= 1'b0;
      flagInf     <= 1'b0;
      flagNaN     <= 1'b0;
      flagNeg     <= 1'b0;
      s_res_o     <= 1'b0;
      e_res_o     <= '0;
      f_res_o     <= '0;
      isToRound_o <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (valid_i) begin
            mant    <= z_i;
            exp     <= EXP_INIT;
            sign    <= s_i;
            special <= anySpecialIn;
            flagZ   <= isZ_i;
            flagInf <= isInf_i;
            flagNaN <= isNaN_i;
            flagNeg <= isNeg_i;
          end
        end
        NORM: begin
          if (!mant[Z_DW-1]) begin
            mant <= mant << 1;
            exp  <= exp - 1'b1;
          end
        end
        ROUND: begin
          // Specials also pass through ROUND. This gives them the same
          // two-cycle accept-to-strobe path as a normal result.
          s_res_o     <= rSign;
          e_res_o     <= rExp;
          f_res_o     <= rFrac;
          isToRound_o <= rInexact;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic. A special operand skips normalization.
  always_comb begin
    // NOTE: stateNext gets a default before the case statement. Every path
    // then assigns it, so no latch is inferred.
    stateNext = state;
    case (state)
      IDLE:    if (valid_i) stateNext = anySpecialIn ? ROUND : NORM;
      NORM:    if (mant[Z_DW-1]) stateNext = ROUND;
      ROUND:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Round-to-nearest-even on the normalized mantissa, with special-case override.
  always_comb begin
    frac     = mant[Z_DW-2 -: F_DW];
    guard    = mant[ST_DW];
    sticky   = |mant[ST_DW-1:0];
    incr     = guard & (sticky | frac[0]);
    fracSum  = {1'b0, frac} + {{F_DW{1'b0}}, incr};
    rSign    = sign;
    rExp     = fracSum[F_DW] ? exp + 1'b1 : exp;
    rFrac    = fracSum[F_DW-1:0];
    rInexact = guard | sticky;
    if (special) begin
      rInexact = 1'b0;
      if (flagNaN || (flagNeg && !flagZ)) begin
        rSign = 1'b0;
        rExp  = EXP_ONES;
        rFrac = QNAN_F;
      end else if (flagZ) begin
        rSign = 1'b1;
        rExp  = EXP_ONES;
        rFrac = '0;
      end else if (flagInf) begin
        rSign = 1'b0;
        rExp  = EXP_ONES;
        rFrac = '0;
      end else begin
        rSign = sign;
        rExp  = '0;
        rFrac = '0;
      end
    end
  end

endmodule

// File: tb/tb_lampfpu_log_norm.sv
// Directed-vector bench for lampfpu_log_norm. Expected results are hand-computed bfloat16 words.
module tb_lampfpu_log_norm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        s_i = 1'b0;
  logic [24:0] z_i = '0;
  logic        isZ_i = 1'b0, isInf_i = 1'b0, isNaN_i = 1'b0, isNeg_i = 1'b0;
  logic        s_res_o;
  logic [7:0]  e_res_o;
  logic [6:0]  f_res_o;
  logic        valid_o, isOverflow_o, isUnderflow_o, isToRound_o;

  int nCompared = 0;
  int nMismatched = 0;

  lampfpu_log_norm dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .s_i(s_i), .z_i(z_i),
    .isZ_i(isZ_i), .isInf_i(isInf_i), .isNaN_i(isNaN_i), .isNeg_i(isNeg_i),
    .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o), .valid_o(valid_o),
    .isOverflow_o(isOverflow_o), .isUnderflow_o(isUnderflow_o), .isToRound_o(isToRound_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operand. Then count edges, with the accept edge counted as 1,
  // until valid_o appears.
  task automatic runOp(input string tag, input logic [24:0] z, input logic s,
                       input logic [3:0] flags, input logic [15:0] expRes,
                       input logic expRnd, input int expLat);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; z_i = z; s_i = s;
    {isZ_i, isInf_i, isNaN_i, isNeg_i} = flags;
    @(posedge clk); #1;
    valid_i = 1'b0;
    {isZ_i, isInf_i, isNaN_i, isNeg_i} = 4'b0;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " result"}, 32'({s_res_o, e_res_o, f_res_o}), 32'(expRes));
    check({tag, " inexact"}, 32'(isToRound_o), 32'(expRnd));
    @(posedge clk); #1;
    check({tag, " strobe width"}, 32'(valid_o), 32'd0);
    check({tag, " ready back"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int lat;
    int extra;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset ready", 32'(ready_o), 32'd1);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    check("reset flags", 32'({isOverflow_o, isUnderflow_o, isToRound_o}), 32'd0);

    // Normal operands: k = 9, 0, 8, 8.
    runOp("ln2",       25'h000B172, 1'b0, 4'b0000, 16'h3F31, 1'b1, 12);
    runOp("carry",     25'h1FFFFFF, 1'b0, 4'b0000, 16'h4400, 1'b1, 3);
    runOp("tie noinc", 25'h0010100, 1'b1, 4'b0000, 16'hBF80, 1'b1, 11);
    runOp("tie inc",   25'h0010300, 1'b1, 4'b0000, 16'hBF82, 1'b1, 11);
    // Specials. The flags vector is {isZ, isInf, isNaN, isNeg}.
    runOp("sp zero",   25'h0000000, 1'b0, 4'b1000, 16'hFF80, 1'b0, 2);
    runOp("sp neg",    25'h000B172, 1'b1, 4'b0001, 16'h7FC0, 1'b0, 2);
    runOp("sp nan",    25'h0010300, 1'b0, 4'b0010, 16'h7FC0, 1'b0, 2);
    runOp("sp inf",    25'h0000000, 1'b0, 4'b0100, 16'h7F80, 1'b0, 2);
    runOp("sp ln1",    25'h0000000, 1'b0, 4'b0000, 16'h0000, 1'b0, 2);
    runOp("sp ln1 neg",25'h0000000, 1'b1, 4'b0000, 16'h8000, 1'b0, 2);
    runOp("sp -0",     25'h0000000, 1'b1, 4'b1001, 16'hFF80, 1'b0, 2);
    runOp("sp nan+inf",25'h0000000, 1'b0, 4'b0110, 16'h7FC0, 1'b0, 2);

    // Hold valid_i high for the whole busy period. Only the first operand counts.
    @(negedge clk);
    valid_i = 1'b1; z_i = 25'h000B172; s_i = 1'b0;
    @(posedge clk); #1;
    z_i = 25'h1FFFFFF; s_i = 1'b1;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    valid_i = 1'b0;
    check("busy latency", 32'(lat), 32'd12);
    check("busy result", 32'({s_res_o, e_res_o, f_res_o}), 32'h3F31);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (valid_o) extra++;
    end
    check("busy extra strobes", 32'(extra), 32'd0);

    // Abort with rst during the 4th NORM cycle.
    @(negedge clk);
    valid_i = 1'b1; z_i = 25'h000B172; s_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort ready", 32'(ready_o), 32'd1);
    check("abort valid", 32'(valid_o), 32'd0);
    check("abort result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
    check("abort inexact", 32'(isToRound_o), 32'd0);
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o) extra++;
    end
    check("abort strobes", 32'(extra), 32'd0);
    runOp("after abort", 25'h0010300, 1'b1, 4'b0000, 16'hBF82, 1'b1, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
